// File: rtl/dt_peak_scan.sv
// -----------------------------------------------------------------------------
// dt_peak_scan
//
// Post-processing stage for the distance-transform engine. After the engine
// finishes, a start pulse makes this block walk the result memory in raster
// order ({y,x} address, x fastest). It reports:
//   - the largest distance value,
//   - the (x,y) of its first raster occurrence,
//   - the number of nonzero (foreground) pixels.
// The block shares the result-memory port with the DT engine. The engine is
// idle whenever busy is high.
//
// Optional feature (compile-time macro DT_PEAK_CLEAR_EN):
//   Each pixel takes two cycles: a read cycle, then a write of 0 to the same
//   address. The memory is left all zero for the next frame. Without the
//   macro, res_wr is tied low and each pixel takes one read cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   start     in   single-cycle scan request (ignored while busy)
//   busy      out  scan in progress
//   done      out  results valid; held until the next accepted start
//   res_rd    out  result-memory read enable
//   res_wr    out  result-memory write enable (clear feature only)
//   res_addr  out  result-memory address {y,x}
//   res_do    out  result-memory write data (always 0)
//   res_di    in   result-memory read data (combinational)
//   max_val   out  maximum distance value
//   max_x     out  x of first maximum
//   max_y     out  y of first maximum
//   fg_cnt    out  count of nonzero pixels (0 .. 2**(W_LOG2+H_LOG2))
// -----------------------------------------------------------------------------
module dt_peak_scan #(
    parameter int W_LOG2 = 7,
    parameter int H_LOG2 = 7,
    parameter int DW     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     res_rd,
    output logic                     res_wr,
    output logic [W_LOG2+H_LOG2-1:0] res_addr,
    output logic [DW-1:0]            res_do,
    input  logic [DW-1:0]            res_di,
    output logic [DW-1:0]            max_val,
    output logic [W_LOG2-1:0]        max_x,
    output logic [H_LOG2-1:0]        max_y,
    output logic [W_LOG2+H_LOG2:0]   fg_cnt
);

    localparam int AW = W_LOG2 + H_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    max_q;
    logic [W_LOG2-1:0] mx_q;
    logic [H_LOG2-1:0] my_q;
    logic [AW:0]      cnt_q;
`ifdef DT_PEAK_CLEAR_EN
    logic             wr_q;
`endif

    // Statistics candidates for the pixel sampled this cycle.
    logic             last_px;
    logic             is_fg;
    logic             new_max;
    logic [AW:0]      cnt_d;
    logic [DW-1:0]    max_d;
    logic [W_LOG2-1:0] mx_d;
    logic [H_LOG2-1:0] my_d;

    always_comb begin
        last_px = &addr_q;
        is_fg   = (res_di != '0);
        // Strict compare: a tie keeps the earlier raster position.
        new_max = (res_di > max_q);
        cnt_d   = cnt_q + {{AW{1'b0}}, is_fg};
        max_d   = new_max ? res_di : max_q;
        mx_d    = new_max ? addr_q[W_LOG2-1:0] : mx_q;
        my_d    = new_max ? addr_q[AW-1:W_LOG2] : my_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            max_q   <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            cnt_q   <= '0;
`ifdef DT_PEAK_CLEAR_EN
            wr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        rd_q    <= 1'b1;
                        addr_q  <= '0;
                        max_q   <= '0;
                        mx_q    <= '0;
                        my_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                SCAN: begin
                    cnt_q <= cnt_d;
                    max_q <= max_d;
                    mx_q  <= mx_d;
                    my_q  <= my_d;
`ifdef DT_PEAK_CLEAR_EN
                    // Follow every read with a clearing write to the same address.
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b1;
                    state_q <= WRITE;
`else
                    if (!last_px) begin
                        addr_q <= addr_q + 1'b1;
                    end else begin
                        // Final pixel: results and done land on the same edge.
                        rd_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
`endif
                end
`ifdef DT_PEAK_CLEAR_EN
                WRITE: begin
                    wr_q <= 1'b0;
                    if (!last_px) begin
                        addr_q  <= addr_q + 1'b1;
                        rd_q    <= 1'b1;
                        state_q <= SCAN;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_rd   = rd_q;
    assign res_addr = addr_q;
    assign res_do   = '0;
    assign max_val  = max_q;
    assign max_x    = mx_q;
    assign max_y    = my_q;
    assign fg_cnt   = cnt_q;
`ifdef DT_PEAK_CLEAR_EN
    assign res_wr   = wr_q;
`else
    assign res_wr   = 1'b0;
`endif

endmodule

// File: tb/tb_dt_peak_scan.sv
// -----------------------------------------------------------------------------
// tb_dt_peak_scan
//
// Self-checking bench for dt_peak_scan. It holds a behavioural model of the
// 128x128 result memory and a plain reference computation of the scan
// results. Build with DT_PEAK_CLEAR_EN defined to exercise the clearing scan.
// -----------------------------------------------------------------------------
module tb_dt_peak_scan;

    localparam int WL   = 7;
    localparam int HL   = 7;
    localparam int NPIX = 1 << (WL + HL);
`ifdef DT_PEAK_CLEAR_EN
    localparam int SCAN_CYC = 2 * NPIX;
`else
    localparam int SCAN_CYC = NPIX;
`endif
    localparam int LIMIT = SCAN_CYC + 100;

    logic               clk;
    logic               reset;
    logic               start;
    logic               busy;
    logic               done;
    logic               res_rd;
    logic               res_wr;
    logic [WL+HL-1:0]   res_addr;
    logic [7:0]         res_do;
    logic [7:0]         res_di;
    logic [7:0]         max_val;
    logic [WL-1:0]      max_x;
    logic [HL-1:0]      max_y;
    logic [WL+HL:0]     fg_cnt;

    logic [7:0] mem [0:NPIX-1];

    int checks = 0;
    int errors = 0;

    dt_peak_scan #(.W_LOG2(WL), .H_LOG2(HL), .DW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_wr   (res_wr),
        .res_addr (res_addr),
        .res_do   (res_do),
        .res_di   (res_di),
        .max_val  (max_val),
        .max_x    (max_x),
        .max_y    (max_y),
        .fg_cnt   (fg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign res_di = mem[res_addr];

`ifdef DT_PEAK_CLEAR_EN
    always @(posedge clk) begin
        if (res_wr) mem[res_addr] = res_do;
    end
`endif

    // Reference: raster walk, strict greater-than keeps the first maximum.
    task automatic ref_scan(output logic [7:0] mv, output int mx, output int my, output int cnt);
        mv = 8'd0; mx = 0; my = 0; cnt = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (mem[i] != 8'd0) cnt++;
            if (mem[i] > mv) begin
                mv = mem[i];
                mx = i % (1 << WL);
                my = i / (1 << WL);
            end
        end
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) mem[i] = v;
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase
    // just after the edge that accepted start.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done, plus read/write activity seen along the way.
    // A nonnegative repulse_at raises start again during that cycle.
    task automatic wait_done(input int repulse_at, output int cyc, output int rdc,
                             output int wrc, output int both);
        cyc = 0; rdc = 0; wrc = 0; both = 0;
        while (!done && cyc < LIMIT) begin
            if (res_rd) rdc++;
            if (res_wr) wrc++;
            if (res_rd && res_wr) both++;
            start = (cyc == repulse_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        fill_mem(8'd0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, res_rd, res_wr, res_addr, max_val, max_x, max_y, fg_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rd=%b wr=%b addr=%0d max=%0d x=%0d y=%0d cnt=%0d, required all 0",
                     busy, done, res_rd, res_wr, res_addr, max_val, max_x, max_y, fg_cnt);
        end
        checks++;
        if (res_do !== 8'd0) begin
            errors++;
            $display("FAIL reset_res_do: got %0d required 0", res_do);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, res_rd, res_wr} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_hold: busy/done/rd/wr=%b required 0000", {busy, done, res_rd, res_wr});
        end
    endtask

    task automatic test_all_zero();
        int cyc, rdc, wrc, both;
        fill_mem(8'd0);
        pulse_start();
        checks++;
        if ({busy, done, res_rd, res_addr} !== {1'b1, 1'b0, 1'b1, 14'd0}) begin
            errors++;
            $display("FAIL zero_accept: busy=%b done=%b rd=%b addr=%0d required 1 0 1 0", busy, done, res_rd, res_addr);
        end
        wait_done(-1, cyc, rdc, wrc, both);
        checks++;
        if (cyc != NPIX || rdc != NPIX) begin
            errors++;
            $display("FAIL zero_latency: cycles=%0d reads=%0d required %0d %0d", cyc, rdc, NPIX, NPIX);
        end
        checks++;
        if (wrc != 0) begin
            errors++;
            $display("FAIL zero_no_write: writes=%0d required 0", wrc);
        end
        checks++;
        if ({max_val, max_x, max_y, fg_cnt} !== '0) begin
            errors++;
            $display("FAIL zero_results: max=%0d x=%0d y=%0d cnt=%0d required all 0", max_val, max_x, max_y, fg_cnt);
        end
        checks++;
        if ({busy, res_rd, res_addr} !== {1'b0, 1'b0, 14'h3FFF}) begin
            errors++;
            $display("FAIL zero_end_state: busy=%b rd=%b addr=%0d required 0 0 16383", busy, res_rd, res_addr);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_hold: done=%b busy=%b required 1 0", done, busy);
        end
    endtask

    task automatic test_single_pixel();
        int cyc, rdc, wrc, both;
        fill_mem(8'd0);
        mem[9 * 128 + 5] = 8'd3;
        pulse_start();
        wait_done(-1, cyc, rdc, wrc, both);
        checks++;
        if (cyc != SCAN_CYC) begin
            errors++;
            $display("FAIL single_latency: cycles=%0d required %0d", cyc, SCAN_CYC);
        end
        checks++;
        if (max_val !== 8'd3 || max_x !== 7'd5 || max_y !== 7'd9 || fg_cnt !== 15'd1) begin
            errors++;
            $display("FAIL single_results: max=%0d x=%0d y=%0d cnt=%0d required 3 5 9 1", max_val, max_x, max_y, fg_cnt);
        end
    endtask

    task automatic test_restart();
        int cyc, rdc, wrc, both;
        fill_mem(8'd1);
        mem[2 * 128 + 10] = 8'd7;
        mem[100 * 128 + 4] = 8'd7;
        pulse_start();
        wait_done(100, cyc, rdc, wrc, both);
        checks++;
        if (cyc != NPIX || rdc != NPIX) begin
            errors++;
            $display("FAIL busy_start_ignored: cycles=%0d reads=%0d required %0d %0d", cyc, rdc, NPIX, NPIX);
        end
        checks++;
        if (max_val !== 8'd7 || max_x !== 7'd10 || max_y !== 7'd2 || fg_cnt !== 15'd16384) begin
            errors++;
            $display("FAIL tie_results: max=%0d x=%0d y=%0d cnt=%0d required 7 10 2 16384", max_val, max_x, max_y, fg_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        pulse_start();
        checks++;
        if ({done, busy, res_rd, res_addr, max_val, fg_cnt} !== {1'b0, 1'b1, 1'b1, 14'd0, 8'd0, 15'd0}) begin
            errors++;
            $display("FAIL done_restart: done=%b busy=%b rd=%b addr=%0d max=%0d cnt=%0d required 0 1 1 0 0 0",
                     done, busy, res_rd, res_addr, max_val, fg_cnt);
        end
        wait_done(-1, cyc, rdc, wrc, both);
        checks++;
        if (cyc != NPIX || max_val !== 8'd7 || max_x !== 7'd10 || max_y !== 7'd2 || fg_cnt !== 15'd16384) begin
            errors++;
            $display("FAIL rescan_results: cycles=%0d max=%0d x=%0d y=%0d cnt=%0d required %0d 7 10 2 16384",
                     cyc, max_val, max_x, max_y, fg_cnt, NPIX);
        end
    endtask

    task automatic test_reset_midscan();
        int cyc, rdc, wrc, both;
        logic [7:0] ev;
        int ex, ey, ec;
        for (int i = 0; i < NPIX; i++) begin
            int v;
            v = $urandom_range(0, 31);
            mem[i] = (v > 15) ? 8'd0 : 8'(v);
        end
        pulse_start();
        repeat (4999) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, res_rd, res_wr, res_addr, max_val, max_x, max_y, fg_cnt} !== '0) begin
            errors++;
            $display("FAIL async_abort: busy=%b done=%b rd=%b addr=%0d max=%0d cnt=%0d required all 0",
                     busy, done, res_rd, res_addr, max_val, fg_cnt);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, res_rd} !== 3'b000) begin
            errors++;
            $display("FAIL abort_idle: busy/done/rd=%b required 000", {busy, done, res_rd});
        end
        ref_scan(ev, ex, ey, ec);
        pulse_start();
        wait_done(-1, cyc, rdc, wrc, both);
        checks++;
        if (cyc != NPIX || max_val !== ev || max_x !== 7'(ex) || max_y !== 7'(ey) || fg_cnt !== 15'(ec)) begin
            errors++;
            $display("FAIL random_scan: cycles=%0d max=%0d x=%0d y=%0d cnt=%0d required %0d %0d %0d %0d %0d",
                     cyc, max_val, max_x, max_y, fg_cnt, NPIX, ev, ex, ey, ec);
        end
    endtask

`ifdef DT_PEAK_CLEAR_EN
    task automatic test_clear();
        int cyc, rdc, wrc, both, nz;
        fill_mem(8'h20);
        pulse_start();
        wait_done(-1, cyc, rdc, wrc, both);
        checks++;
        if (cyc != 2 * NPIX || rdc != NPIX || wrc != NPIX) begin
            errors++;
            $display("FAIL clear_latency: cycles=%0d reads=%0d writes=%0d required %0d %0d %0d",
                     cyc, rdc, wrc, 2 * NPIX, NPIX, NPIX);
        end
        checks++;
        if (both != 0) begin
            errors++;
            $display("FAIL clear_rd_wr_overlap: overlap cycles=%0d required 0", both);
        end
        checks++;
        if (max_val !== 8'h20 || max_x !== 7'd0 || max_y !== 7'd0 || fg_cnt !== 15'd16384) begin
            errors++;
            $display("FAIL clear_results: max=%0d x=%0d y=%0d cnt=%0d required 32 0 0 16384", max_val, max_x, max_y, fg_cnt);
        end
        nz = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] != 8'd0) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL clear_memory: nonzero pixels=%0d required 0", nz);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        test_reset();
`ifdef DT_PEAK_CLEAR_EN
        test_clear();
        test_single_pixel();
`else
        test_all_zero();
        test_single_pixel();
        test_restart();
        test_reset_midscan();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
